// File: rtl/ramb_arbiter_if.sv
// ---------------------------------------------------------------------------
// ramb_arbiter_if
//   Bundles the requester-side handshake and the ramb_* memory bus of the
//   upper-RAM port B arbiter.
//
//   Requester side : rq_rd_i/rq_wr_i (level requests), per-requester address
//                    and write data, rq_ack_o completion pulses, rq_data_o
//                    read data, err_o timeout pulse.
//   Memory side    : ramb_addr/ramb_dout/ramb_wr/ramb_rd towards upper_ram,
//                    ramb_din/ramb_wr_ack/ramb_rd_ack back from it.
//
//   Modports:
//     master - the arbiter itself (drives the ramb_* strobes and rq_* replies)
//     slave  - the surrounding system (requesters plus memory)
// ---------------------------------------------------------------------------
interface ramb_arbiter_if #(
  parameter int ADDR_W = 16
);
  logic [1:0]        rq_rd_i;
  logic [1:0]        rq_wr_i;
  logic [ADDR_W-1:0] rq0_addr_i;
  logic [ADDR_W-1:0] rq1_addr_i;
  logic [7:0]        rq0_data_i;
  logic [7:0]        rq1_data_i;
  logic [1:0]        rq_ack_o;
  logic [7:0]        rq_data_o;
  logic              err_o;
  logic [ADDR_W-1:0] ramb_addr;
  logic              ramb_wr;
  logic              ramb_rd;
  logic [7:0]        ramb_dout;
  logic [7:0]        ramb_din;
  logic              ramb_wr_ack;
  logic              ramb_rd_ack;

  modport master (
    input  rq_rd_i, rq_wr_i, rq0_addr_i, rq1_addr_i, rq0_data_i, rq1_data_i,
    input  ramb_din, ramb_wr_ack, ramb_rd_ack,
    output rq_ack_o, rq_data_o, err_o,
    output ramb_addr, ramb_wr, ramb_rd, ramb_dout
  );

  modport slave (
    output rq_rd_i, rq_wr_i, rq0_addr_i, rq1_addr_i, rq0_data_i, rq1_data_i,
    output ramb_din, ramb_wr_ack, ramb_rd_ack,
    input  rq_ack_o, rq_data_o, err_o,
    input  ramb_addr, ramb_wr, ramb_rd, ramb_dout
  );
endinterface

// File: rtl/ramb_arbiter.sv
// ---------------------------------------------------------------------------
// ramb_arbiter
//   Two-requester round-robin arbiter for the shared upper-RAM port B.
//   Requester 0 is the AdamNet disk/DMA engine, requester 1 the secondary
//   loader path. One byte access is in flight at a time; each completes with
//   a one-cycle rq_ack_o pulse, either on the matching memory ack or, if the
//   memory never answers, after TIMEOUT_CYCLES WAIT cycles with err_o and
//   read data forced to 8'hFF.
//
//   Ports:
//     clk_i      - system clock
//     reset_n_i  - synchronous active-low reset
//     bus        - ramb_arbiter_if.master (requests, replies, ramb_* bus)
//   Optional (macro RAMB_ARB_STATS_EN):
//     grant_cnt0_o  - saturating completion count, requester 0
//     grant_cnt1_o  - saturating completion count, requester 1
//     timeout_cnt_o - saturating timeout completion count
//
//   Parameters:
//     ADDR_W         - ramb address width (must match the interface)
//     TIMEOUT_CYCLES - WAIT cycles before forced completion, >= 2
// ---------------------------------------------------------------------------
module ramb_arbiter #(
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic           clk_i,
  input  logic           reset_n_i,
  ramb_arbiter_if.master bus
`ifdef RAMB_ARB_STATS_EN
  ,
  output logic [15:0]    grant_cnt0_o,
  output logic [15:0]    grant_cnt1_o,
  output logic [7:0]     timeout_cnt_o
`endif
);

  // Counter only has to reach TIMEOUT_CYCLES-1.
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // One-hot encoding of a requester id, used for ack and holdoff mask.
  function automatic logic [1:0] onehot2(input logic id);
    if (id) begin
      return 2'b10;
    end else begin
      return 2'b01;
    end
  endfunction

  state_t            state_r;
  logic              last_grant_r;
  logic              gnt_r;
  logic              op_wr_r;
  logic [1:0]        mask_r;
  logic [CNT_W-1:0]  tmo_cnt_r;

  logic [1:0]        elig_s;
  logic              grant_valid_s;
  logic              grant_id_s;
  logic              grant_wr_s;
  logic [ADDR_W-1:0] grant_addr_s;
  logic [7:0]        grant_data_s;
  logic              ack_hit_s;
  logic              tmo_hit_s;
  logic              done_s;

  // Request selection: eligible requesters, round-robin tie break, operand mux.
  always_comb begin
    elig_s        = (bus.rq_rd_i | bus.rq_wr_i) & ~mask_r;
    grant_valid_s = |elig_s;
    if (elig_s == 2'b11) begin
      grant_id_s = ~last_grant_r;
    end else if (elig_s[1]) begin
      grant_id_s = 1'b1;
    end else begin
      grant_id_s = 1'b0;
    end
    // Write wins when rd and wr are both raised.
    if (grant_id_s) begin
      grant_wr_s   = bus.rq_wr_i[1];
      grant_addr_s = bus.rq1_addr_i;
      grant_data_s = bus.rq1_data_i;
    end else begin
      grant_wr_s   = bus.rq_wr_i[0];
      grant_addr_s = bus.rq0_addr_i;
      grant_data_s = bus.rq0_data_i;
    end
  end

  // Completion detection: only the ack matching the latched op counts.
  always_comb begin
    if (op_wr_r) begin
      ack_hit_s = bus.ramb_wr_ack;
    end else begin
      ack_hit_s = bus.ramb_rd_ack;
    end
    tmo_hit_s = (tmo_cnt_r == TMO_LAST);
    if (state_r == ST_WAIT) begin
      done_s = ack_hit_s | tmo_hit_s;
    end else begin
      done_s = 1'b0;
    end
  end

  // Arbiter FSM with registered strobes, replies and round-robin state.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r       <= ST_IDLE;
      last_grant_r  <= 1'b1;
      gnt_r         <= 1'b0;
      op_wr_r       <= 1'b0;
      mask_r        <= 2'b00;
      tmo_cnt_r     <= {CNT_W{1'b0}};
      bus.rq_ack_o  <= 2'b00;
      bus.rq_data_o <= 8'h00;
      bus.err_o     <= 1'b0;
      bus.ramb_addr <= {ADDR_W{1'b0}};
      bus.ramb_wr   <= 1'b0;
      bus.ramb_rd   <= 1'b0;
      bus.ramb_dout <= 8'h00;
    end else begin
      // Strobes and reply pulses last a single cycle.
      bus.ramb_wr  <= 1'b0;
      bus.ramb_rd  <= 1'b0;
      bus.rq_ack_o <= 2'b00;
      bus.err_o    <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // The holdoff mask only ever covers the first IDLE cycle.
          mask_r <= 2'b00;
          if (grant_valid_s) begin
            state_r       <= ST_WAIT;
            gnt_r         <= grant_id_s;
            op_wr_r       <= grant_wr_s;
            bus.ramb_addr <= grant_addr_s;
            tmo_cnt_r     <= {CNT_W{1'b0}};
            if (grant_wr_s) begin
              bus.ramb_dout <= grant_data_s;
              bus.ramb_wr   <= 1'b1;
            end else begin
              bus.ramb_rd   <= 1'b1;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (done_s) begin
            state_r      <= ST_IDLE;
            bus.rq_ack_o <= onehot2(gnt_r);
            last_grant_r <= gnt_r;
            mask_r       <= onehot2(gnt_r);
            // An ack on the timeout edge still counts as a clean completion.
            bus.err_o    <= ~ack_hit_s;
            if (!op_wr_r) begin
              if (ack_hit_s) begin
                bus.rq_data_o <= bus.ramb_din;
              end else begin
                bus.rq_data_o <= 8'hFF;
              end
            end else begin
              bus.rq_data_o <= bus.rq_data_o;
            end
          end else begin
            tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef RAMB_ARB_STATS_EN
  // Saturating completion and timeout statistics.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      grant_cnt0_o  <= 16'h0000;
      grant_cnt1_o  <= 16'h0000;
      timeout_cnt_o <= 8'h00;
    end else if (done_s) begin
      if (gnt_r) begin
        if (grant_cnt1_o != 16'hFFFF) begin
          grant_cnt1_o <= grant_cnt1_o + 16'd1;
        end
      end else begin
        if (grant_cnt0_o != 16'hFFFF) begin
          grant_cnt0_o <= grant_cnt0_o + 16'd1;
        end
      end
      if (!ack_hit_s && (timeout_cnt_o != 8'hFF)) begin
        timeout_cnt_o <= timeout_cnt_o + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ramb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ramb_arbiter
//   Directed self-checking bench for ramb_arbiter. A behavioural memory with
//   programmable ack latency, ack suppression and ack-type swapping stands in
//   for upper_ram; a monitor flags overlapping/long strobes and illegal ack
//   patterns.
// ---------------------------------------------------------------------------
module tb_ramb_arbiter;
  localparam int ADDR_W = 16;
  localparam int TMO    = 15;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ramb_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef RAMB_ARB_STATS_EN
  logic [15:0] grant_cnt0;
  logic [15:0] grant_cnt1;
  logic [7:0]  timeout_cnt;
`endif

  ramb_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
`ifdef RAMB_ARB_STATS_EN
    ,
    .grant_cnt0_o  (grant_cnt0),
    .grant_cnt1_o  (grant_cnt1),
    .timeout_cnt_o (timeout_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Memory model controls
  logic [7:0]  mem [0:65535];
  int          lat;
  logic        ack_en;
  logic        wrong_ack;
  logic        pre_en;
  logic [15:0] pre_addr;
  logic [7:0]  pre_data;
  int          left_r;
  logic        pend_wr_r;

  // Memory model: writes/reads on strobe, ack 'lat' cycles after the strobe.
  always @(posedge clk) begin
    bus.ramb_wr_ack <= 1'b0;
    bus.ramb_rd_ack <= 1'b0;
    if (pre_en) mem[pre_addr] <= pre_data;
    if (bus.ramb_wr) mem[bus.ramb_addr] <= bus.ramb_dout;
    if (bus.ramb_rd) bus.ramb_din <= mem[bus.ramb_addr];
    if ((bus.ramb_wr || bus.ramb_rd) && ack_en) begin
      pend_wr_r <= bus.ramb_wr;
      if (lat <= 1) begin
        left_r <= 0;
        if (bus.ramb_wr ^ wrong_ack) bus.ramb_wr_ack <= 1'b1;
        else bus.ramb_rd_ack <= 1'b1;
      end else begin
        left_r <= lat - 1;
      end
    end else if (left_r == 1) begin
      left_r <= 0;
      if (pend_wr_r ^ wrong_ack) bus.ramb_wr_ack <= 1'b1;
      else bus.ramb_rd_ack <= 1'b1;
    end else if (left_r > 1) begin
      left_r <= left_r - 1;
    end
  end

  // Protocol monitor
  int         viol;
  logic       prev_strb;
  logic [1:0] prev_ack;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_strb <= 1'b0;
      prev_ack  <= 2'b00;
    end else begin
      prev_strb <= bus.ramb_wr | bus.ramb_rd;
      prev_ack  <= bus.rq_ack_o;
      if ((bus.ramb_wr && bus.ramb_rd) ||
          ((bus.ramb_wr || bus.ramb_rd) && prev_strb) ||
          (bus.rq_ack_o == 2'b11) ||
          ((bus.rq_ack_o & prev_ack) != 2'b00))
        viol <= viol + 1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no end want end");
    $fatal(1);
  end

  task automatic drive_idle();
    bus.rq_rd_i    = 2'b00;
    bus.rq_wr_i    = 2'b00;
    bus.rq0_addr_i = 16'h0000;
    bus.rq1_addr_i = 16'h0000;
    bus.rq0_data_i = 8'h00;
    bus.rq1_data_i = 8'h00;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // Waits for an rq_ack_o pulse; cyc = -1 when the budget expires.
  task automatic wait_ack(input int budget, output int cyc, output logic [1:0] ack,
                          output logic err, output logic [7:0] data);
    bit done = 1'b0;
    cyc = -1; ack = 2'b00; err = 1'b0; data = 8'h00;
    for (int i = 1; i <= budget && !done; i++) begin
      @(negedge clk);
      if (bus.rq_ack_o !== 2'b00) begin
        done = 1'b1; cyc = i; ack = bus.rq_ack_o; err = bus.err_o; data = bus.rq_data_o;
      end
    end
  endtask

  // One access by one requester; strb = {ramb_wr, ramb_rd} in the cycle after the request.
  task automatic single_access(input logic id, input logic rd, input logic wr,
                               input logic [15:0] addr, input logic [7:0] wd,
                               output logic [1:0] strb, output logic [15:0] saddr,
                               output int cyc, output logic [1:0] ack,
                               output logic err, output logic [7:0] data);
    @(negedge clk);
    if (id) begin
      bus.rq1_addr_i = addr; bus.rq1_data_i = wd; bus.rq_rd_i[1] = rd; bus.rq_wr_i[1] = wr;
    end else begin
      bus.rq0_addr_i = addr; bus.rq0_data_i = wd; bus.rq_rd_i[0] = rd; bus.rq_wr_i[0] = wr;
    end
    @(negedge clk);
    strb  = {bus.ramb_wr, bus.ramb_rd};
    saddr = bus.ramb_addr;
    wait_ack(40, cyc, ack, err, data);
    bus.rq_rd_i = 2'b00;
    bus.rq_wr_i = 2'b00;
  endtask

  logic [1:0]  strb, ack;
  logic [15:0] saddr;
  logic        err;
  logic [7:0]  data;
  int          cyc;

  task automatic test_reset();
    apply_reset();
    n_checks++; if (bus.rq_ack_o !== 2'b00) begin n_fail++; $display("FAIL reset_ack: got %b want 00", bus.rq_ack_o); end
    n_checks++; if (bus.rq_data_o !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", bus.rq_data_o); end
    n_checks++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.err_o); end
    n_checks++; if ({bus.ramb_addr, bus.ramb_dout, bus.ramb_wr, bus.ramb_rd} !== 26'd0) begin
      n_fail++; $display("FAIL reset_ramb: got addr=%h dout=%h wr=%b rd=%b want all 0",
                         bus.ramb_addr, bus.ramb_dout, bus.ramb_wr, bus.ramb_rd); end
  endtask

  task automatic test_read();
    preload(16'h0123, 8'h5A);
    single_access(1'b0, 1'b1, 1'b0, 16'h0123, 8'h00, strb, saddr, cyc, ack, err, data);
    n_checks++; if (strb !== 2'b01) begin n_fail++; $display("FAIL read_strobe: got %b want 01", strb); end
    n_checks++; if (saddr !== 16'h0123) begin n_fail++; $display("FAIL read_addr: got %h want 0123", saddr); end
    n_checks++; if (cyc !== 2 || ack !== 2'b01) begin n_fail++; $display("FAIL read_ack: got cyc=%0d ack=%b want cyc=2 ack=01", cyc, ack); end
    n_checks++; if (data !== 8'h5A || err !== 1'b0) begin n_fail++; $display("FAIL read_data: got %h err=%b want 5a err=0", data, err); end
    @(negedge clk);
    n_checks++; if (bus.rq_ack_o !== 2'b00 || bus.rq_data_o !== 8'h5A) begin
      n_fail++; $display("FAIL read_hold: got ack=%b data=%h want 00 5a", bus.rq_ack_o, bus.rq_data_o); end
  endtask

  task automatic test_contention();
    logic [1:0] order [2];
    int n = 0;
    apply_reset();
    @(negedge clk);
    bus.rq0_addr_i = 16'h0010; bus.rq0_data_i = 8'h11;
    bus.rq1_addr_i = 16'h0020; bus.rq1_data_i = 8'h22;
    bus.rq_wr_i = 2'b11;
    for (int i = 0; i < 30 && n < 2; i++) begin
      @(negedge clk);
      if (bus.rq_ack_o != 2'b00) begin
        order[n] = bus.rq_ack_o;
        bus.rq_wr_i = bus.rq_wr_i & ~bus.rq_ack_o;
        n++;
      end
    end
    bus.rq_wr_i = 2'b00;
    n_checks++; if (n != 2 || order[0] !== 2'b01 || order[1] !== 2'b10) begin
      n_fail++; $display("FAIL contention_order: got n=%0d %b,%b want 2 01,10", n, order[0], order[1]); end
    single_access(1'b0, 1'b1, 1'b0, 16'h0010, 8'h00, strb, saddr, cyc, ack, err, data);
    n_checks++; if (data !== 8'h11 || ack !== 2'b01) begin n_fail++; $display("FAIL contention_rb0: got %h ack=%b want 11 01", data, ack); end
    single_access(1'b1, 1'b1, 1'b0, 16'h0020, 8'h00, strb, saddr, cyc, ack, err, data);
    n_checks++; if (data !== 8'h22 || ack !== 2'b10) begin n_fail++; $display("FAIL contention_rb1: got %h ack=%b want 22 10", data, ack); end
  endtask

  task automatic test_fairness();
    int n = 0, n0 = 0, n1 = 0, alt_err = 0;
    logic [1:0] first = 2'b00, prev = 2'b00;
    @(negedge clk);
    bus.rq0_addr_i = 16'h0010; bus.rq1_addr_i = 16'h0020;
    bus.rq_rd_i = 2'b11;
    for (int i = 0; i < 80 && n < 10; i++) begin
      @(negedge clk);
      if (bus.rq_ack_o != 2'b00) begin
        if (n == 0) first = bus.rq_ack_o;
        else if (bus.rq_ack_o == prev) alt_err++;
        if (bus.rq_ack_o == 2'b01) n0++;
        if (bus.rq_ack_o == 2'b10) n1++;
        prev = bus.rq_ack_o;
        n++;
      end
    end
    bus.rq_rd_i = 2'b00;
    n_checks++; if (n0 != 5 || n1 != 5) begin n_fail++; $display("FAIL fair_counts: got %0d/%0d want 5/5", n0, n1); end
    n_checks++; if (alt_err != 0 || first !== 2'b01) begin n_fail++; $display("FAIL fair_alternate: got repeats=%0d first=%b want 0 01", alt_err, first); end
    n_checks++; if (viol != 0) begin n_fail++; $display("FAIL protocol_monitor: got %0d violations want 0", viol); end
  endtask

  task automatic test_timeout();
    ack_en = 1'b0;
    single_access(1'b1, 1'b1, 1'b0, 16'h0030, 8'h00, strb, saddr, cyc, ack, err, data);
    n_checks++; if (strb !== 2'b01 || cyc != 15 || ack !== 2'b10) begin
      n_fail++; $display("FAIL timeout_timing: got strb=%b cyc=%0d ack=%b want 01 15 10", strb, cyc, ack); end
    n_checks++; if (err !== 1'b1 || data !== 8'hFF) begin n_fail++; $display("FAIL timeout_err: got err=%b data=%h want 1 ff", err, data); end
    @(negedge clk);
    n_checks++; if (bus.err_o !== 1'b0 || bus.rq_ack_o !== 2'b00) begin
      n_fail++; $display("FAIL timeout_pulse: got err=%b ack=%b want 0 00", bus.err_o, bus.rq_ack_o); end
    ack_en = 1'b1;
    single_access(1'b1, 1'b1, 1'b0, 16'h0123, 8'h00, strb, saddr, cyc, ack, err, data);
    n_checks++; if (cyc != 2 || data !== 8'h5A || err !== 1'b0) begin
      n_fail++; $display("FAIL timeout_recover: got cyc=%0d data=%h err=%b want 2 5a 0", cyc, data, err); end
  endtask

  task automatic test_timeout_edge();
    lat = 14;
    single_access(1'b0, 1'b1, 1'b0, 16'h0123, 8'h00, strb, saddr, cyc, ack, err, data);
    n_checks++; if (cyc != 15 || err !== 1'b0 || data !== 8'h5A) begin
      n_fail++; $display("FAIL edge_ack_wins: got cyc=%0d err=%b data=%h want 15 0 5a", cyc, err, data); end
    lat = 15;
    single_access(1'b0, 1'b1, 1'b0, 16'h0010, 8'h00, strb, saddr, cyc, ack, err, data);
    n_checks++; if (cyc != 15 || err !== 1'b1 || data !== 8'hFF) begin
      n_fail++; $display("FAIL edge_late_ack: got cyc=%0d err=%b data=%h want 15 1 ff", cyc, err, data); end
    @(negedge clk);
    n_checks++; if (bus.rq_ack_o !== 2'b00 || bus.rq_data_o !== 8'hFF) begin
      n_fail++; $display("FAIL idle_ack_ignored: got ack=%b data=%h want 00 ff", bus.rq_ack_o, bus.rq_data_o); end
    lat = 1;
  endtask

  task automatic test_reset_mid_wait();
    ack_en = 1'b0;
    @(negedge clk);
    bus.rq0_addr_i = 16'h0040; bus.rq0_data_i = 8'h77; bus.rq_wr_i = 2'b01;
    @(negedge clk);
    n_checks++; if (bus.ramb_wr !== 1'b1) begin n_fail++; $display("FAIL midwait_strobe: got %b want 1", bus.ramb_wr); end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if ({bus.rq_ack_o, bus.err_o, bus.rq_data_o, bus.ramb_addr, bus.ramb_dout, bus.ramb_wr, bus.ramb_rd} !== 37'd0) begin
      n_fail++; $display("FAIL midwait_outputs: got ack=%b err=%b data=%h addr=%h dout=%h wr=%b rd=%b want all 0",
                         bus.rq_ack_o, bus.err_o, bus.rq_data_o, bus.ramb_addr, bus.ramb_dout, bus.ramb_wr, bus.ramb_rd); end
    rst_n = 1'b1;
    drive_idle();
    ack_en = 1'b1;
    wait_ack(20, cyc, ack, err, data);
    n_checks++; if (cyc != -1) begin n_fail++; $display("FAIL midwait_no_ack: got ack=%b at %0d want none", ack, cyc); end
    @(negedge clk);
    bus.rq0_addr_i = 16'h0041; bus.rq0_data_i = 8'h33;
    bus.rq1_addr_i = 16'h0042; bus.rq1_data_i = 8'h44;
    bus.rq_wr_i = 2'b11;
    wait_ack(10, cyc, ack, err, data);
    bus.rq_wr_i[0] = 1'b0;
    n_checks++; if (cyc != 3 || ack !== 2'b01 || err !== 1'b0) begin
      n_fail++; $display("FAIL midwait_fresh0: got cyc=%0d ack=%b err=%b want 3 01 0", cyc, ack, err); end
    wait_ack(10, cyc, ack, err, data);
    bus.rq_wr_i = 2'b00;
    n_checks++; if (ack !== 2'b10 || err !== 1'b0) begin n_fail++; $display("FAIL midwait_fresh1: got ack=%b err=%b want 10 0", ack, err); end
  endtask

  task automatic test_rdwr_both();
    single_access(1'b0, 1'b1, 1'b1, 16'h0050, 8'h99, strb, saddr, cyc, ack, err, data);
    n_checks++; if (strb !== 2'b10 || cyc != 2 || ack !== 2'b01 || err !== 1'b0) begin
      n_fail++; $display("FAIL both_write: got strb=%b cyc=%0d ack=%b err=%b want 10 2 01 0", strb, cyc, ack, err); end
    single_access(1'b1, 1'b1, 1'b0, 16'h0050, 8'h00, strb, saddr, cyc, ack, err, data);
    n_checks++; if (data !== 8'h99) begin n_fail++; $display("FAIL both_readback: got %h want 99", data); end
    wrong_ack = 1'b1;
    single_access(1'b0, 1'b1, 1'b1, 16'h0060, 8'h05, strb, saddr, cyc, ack, err, data);
    wrong_ack = 1'b0;
    n_checks++; if (cyc != 15 || ack !== 2'b01 || err !== 1'b1) begin
      n_fail++; $display("FAIL both_rd_ack_ignored: got cyc=%0d ack=%b err=%b want 15 01 1", cyc, ack, err); end
    n_checks++; if (viol != 0) begin n_fail++; $display("FAIL protocol_final: got %0d violations want 0", viol); end
  endtask

  initial begin
    rst_n = 1'b0; lat = 1; ack_en = 1'b1; wrong_ack = 1'b0;
    pre_en = 1'b0; pre_addr = 16'h0000; pre_data = 8'h00;
    drive_idle();
    test_reset();
    test_read();
    test_contention();
    test_fairness();
    test_timeout();
    test_timeout_edge();
    test_reset_mid_wait();
    test_rdwr_both();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ramb_arbiter.md
Name: ramb_arbiter

Overview:
- Two-requester round-robin arbiter for the shared upper-RAM port B (ramb_* bus: addr/wr/rd/dout/din with wr_ack/rd_ack).
- Requester 0 is the AdamNet disk/DMA engine. Requester 1 is the secondary loader path.
- Serialises one byte access at a time, returns read data with a one-cycle ack pulse, and recovers from a missing memory ack via timeout.
- Sits between cv_console-side requesters and the dual-port upper_ram instance.

Parameters:
- ADDR_W, 16, address width of the ramb bus.
- TIMEOUT_CYCLES, 15, WAIT cycles before a forced completion; must be >= 2.

Ports:
- clk_i  in  1  system clock.
- reset_n_i  in  1  synchronous active-low reset.
- rq_rd_i  in  2  per-requester read request; level, held until ack.
- rq_wr_i  in  2  per-requester write request; level, held until ack.
- rq0_addr_i  in  ADDR_W  requester 0 address.
- rq1_addr_i  in  ADDR_W  requester 1 address.
- rq0_data_i  in  8  requester 0 write data.
- rq1_data_i  in  8  requester 1 write data.
- rq_ack_o  out  2  per-requester one-cycle completion pulse.
- rq_data_o  out  8  read data; valid in the ack cycle, held until next read completion.
- err_o  out  1  one-cycle pulse on a timeout completion.
- ramb_addr  out  ADDR_W  memory address.
- ramb_wr  out  1  one-cycle write strobe.
- ramb_rd  out  1  one-cycle read strobe.
- ramb_dout  out  8  memory write data.
- ramb_din  in  8  memory read data.
- ramb_wr_ack  in  1  write ack from memory.
- ramb_rd_ack  in  1  read ack from memory.

Behaviour:
- Synchronous reset, active low. All outputs are 0 (ramb_addr=0, rq_data_o=0). State=IDLE, last_grant=1 so requester 0 wins the first tie. Timeout counter=0, holdoff mask=0.
- Reset mid-access abandons the access with no ack and no err.
- Requests are sampled only in IDLE. Request i is eligible if (rq_rd_i[i] | rq_wr_i[i]) & ~mask[i].
- If rd and wr are both high for one requester, the access is a write.
- Selection: one eligible requester is granted. If both are eligible, grant the requester != last_grant.
- IDLE -> WAIT on grant, same edge:
  - latch op, grant id, ramb_addr and ramb_dout (for writes);
  - assert ramb_wr or ramb_rd for exactly one cycle;
  - clear the timeout counter.
- WAIT: ramb_addr and ramb_dout stay stable. The strobe is deasserted after its first cycle.
- WAIT completion on ack: completes on ramb_wr_ack (write op) or ramb_rd_ack (read op). The other ack is ignored. On that edge:
  - rq_ack_o[g] <= 1;
  - rq_data_o <= ramb_din (reads only);
  - last_grant <= g; mask <= one-hot(g);
  - state <= IDLE.
- WAIT completion on timeout: the counter increments each WAIT cycle without an ack. When count == TIMEOUT_CYCLES-1 with no ack, complete as above but with rq_data_o=8'hFF (reads) and err_o=1 for one cycle.
- An ack and the timeout arriving on the same edge count as a normal completion; err_o stays 0.
- The holdoff mask lasts exactly one IDLE cycle after completion and then clears. This cycle covers the requester dropping its request after seeing ack.
- A new grant to the other requester may occur in the holdoff cycle.
- Latency with the 1-cycle memory ack: request high in cycle 0, strobe in cycle 1, memory ack in cycle 2, rq_ack_o in cycle 3. Back-to-back throughput is one access per 4 cycles.
- Acks arriving in IDLE are ignored.
- rq_ack_o is never high for both bits at once and never high for two consecutive cycles on the same bit.

Optional Feature:
- Macro: RAMB_ARB_STATS_EN.
- When defined, adds three outputs:
  - grant_cnt0_o (16): completions for requester 0.
  - grant_cnt1_o (16): completions for requester 1.
  - timeout_cnt_o (8): timeout completions.
- All three counters saturate at all-ones and reset to 0.
- When undefined, these ports and their logic are absent and behaviour is otherwise identical.

Test Plan:
- Read: preload addr 16'h0123=8'h5A; req0 read -> ramb_rd in cycle 1, rq_ack_o=2'b01 in cycle 3, rq_data_o=8'h5A, err_o=0.
- Contention: req0 and req1 write together (0x0010=0x11, 0x0020=0x22) from reset -> req0 served first, then req1. Readback gives 0x11 and 0x22, with no overlapping strobes.
- Fairness: both request continuously for 10 accesses -> grants alternate 0,1,0,1…; each gets 5 acks; no double ack.
- Timeout: memory ack suppressed, req1 read, TIMEOUT_CYCLES=15 -> rq_ack_o[1] and err_o pulse 15 cycles after the strobe, rq_data_o=8'hFF, arbiter returns to IDLE.
- Reset mid-WAIT: reset_n_i low for 1 cycle during a pending req0 write -> no ack, all outputs 0, last_grant=1. A fresh request completes normally after release.
- Both rd and wr high on req0 -> a write is issued (ramb_wr=1, ramb_rd=0); completion waits for ramb_wr_ack only.
